fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the pipelined RV32I core.
- Owns the PC and issues requests to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned words in a small FIFO, and presents inst/pc/pc+4/valid to decode, where immgen and the control decoder consume them.
- Handles stalls from the hazard unit and redirects (taken branch/jump) from EX.

---
 rtl/fetch_stage_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 43 ++++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants, state encoding and FIFO entry type for the fetch stage
package fetch_stage_pkg;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  typedef enum logic {FS_RUN = 1'b0, FS_DROP = 1'b1} fetch_state_e;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small power-of-two FIFO holding fetched words tagged with their PC
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int  BUF_DEPTH = 2,
  parameter type entry_t   = fetch_entry_t
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  entry_t                       push_data_i,
  input  logic                         pop_i,
  output entry_t                       head_o,
  output logic [$clog2(BUF_DEPTH):0]   count_o,
  output logic                         empty_o
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  entry_t        r_mem [BUF_DEPTH];
  logic          w_push, w_pop;
  assign w_pop   = pop_i & (r_count != '0);
  assign w_push  = push_i & ((r_count != CW'(BUF_DEPTH)) | w_pop);
  assign head_o  = r_mem[r_rptr];
  assign count_o = r_count;
  assign empty_o = r_count == '0;
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_data_i;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with IF/ID register; FETCH_MISALIGN_TRAP_EN adds a misaligned-redirect trap
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_rvalid_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic        id_valid_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        if_misalign_o
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  logic [31:0]  r_pc, r_req_pc, r_id_inst, r_id_pc, r_id_pc4;
  logic         r_inflight, r_id_valid;
  fetch_state_e r_state;
  logic [CW-1:0] w_count, w_occ;
  fetch_entry_t w_head, w_resp, w_src;
  logic w_empty, w_halt, w_resp_ok, w_load, w_bypass, w_push, w_pop, w_src_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_misalign <= 1'b0;
    else if (redirect_i) r_misalign <= |redirect_pc_i[1:0];
  end
  assign w_halt        = r_misalign;
  assign if_misalign_o = r_misalign;
`else
  assign w_halt = 1'b0;
`endif
  assign w_occ       = w_count + CW'(r_inflight);
  assign imem_req_o  = ~rst_i & ~redirect_i & ~w_halt & (w_occ < CW'(BUF_DEPTH));
  assign imem_addr_o = r_pc;
  assign w_resp_ok   = imem_rvalid_i & r_inflight & (r_state == FS_RUN) & ~redirect_i;
  assign w_resp      = '{inst: imem_rdata_i, pc: r_req_pc};
  assign w_load      = ~stall_i | ~r_id_valid;
  assign w_pop       = w_load & ~w_empty & ~redirect_i;
  assign w_bypass    = w_load & w_empty & w_resp_ok;
  assign w_push      = w_resp_ok & ~w_bypass;
  assign w_src       = w_empty ? w_resp : w_head;
  assign w_src_valid = ~w_empty | w_resp_ok;
  assign id_inst_o   = r_id_inst;
  assign id_pc_o     = r_id_pc;
  assign id_pc4_o    = r_id_pc4;
  assign id_valid_o  = r_id_valid;
  fetch_fifo #(
    .BUF_DEPTH (BUF_DEPTH),
    .entry_t   (fetch_entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (redirect_i),
    .push_i      (w_push),
    .push_data_i (w_resp),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .count_o     (w_count),
    .empty_o     (w_empty)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_state    <= FS_RUN;
      r_id_valid <= 1'b0;
      r_id_inst  <= INST_NOP;
      r_id_pc    <= '0;
      r_id_pc4   <= '0;
    end else begin
      r_inflight <= imem_req_o;
      r_state    <= (redirect_i & r_inflight) ? FS_DROP : FS_RUN;
      if (imem_req_o) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + 32'd4;
      end
      if (redirect_i) r_pc <= align_pc(redirect_pc_i);
      if (redirect_i) begin
        r_id_valid <= 1'b0;
        r_id_inst  <= INST_NOP;
      end else if (w_load) begin
        r_id_valid <= w_src_valid;
        r_id_inst  <= w_src_valid ? w_src.inst : INST_NOP;
        r_id_pc    <= w_src.pc;
        r_id_pc4   <= w_src.pc + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage; FETCH_MISALIGN_TRAP_EN selects trap expectations
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1, stall = 1'b0, redirect = 1'b0, spurious = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic req, rvalid = 1'b0, id_valid;
  logic [31:0] addr, rdata = '0, id_inst, id_pc, id_pc4;
  logic req2, rvalid2 = 1'b0, valid2;
  logic [31:0] addr2, rdata2 = '0, inst2, pc2, pc42;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign, misalign2;
`endif
  int n_checks = 0, n_fail = 0;
  logic mon_en = 1'b0, prev_valid = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 5) | 32'h13;
  endfunction

  always @(posedge clk) begin
    rvalid  <= req | spurious;
    rdata   <= mem_word(addr);
    rvalid2 <= req2;
    rdata2  <= mem_word(addr2);
  end

  fetch_stage dut (
    .clk_i(clk), .rst_i(rst), .imem_req_o(req), .imem_addr_o(addr),
    .imem_rdata_i(rdata), .imem_rvalid_i(rvalid), .stall_i(stall),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .id_inst_o(id_inst),
    .id_pc_o(id_pc), .id_pc4_o(id_pc4), .id_valid_o(id_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .if_misalign_o(misalign)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_rdata_i(rdata2), .imem_rvalid_i(rvalid2), .stall_i(1'b0),
    .redirect_i(1'b0), .redirect_pc_i(32'h0), .id_inst_o(inst2),
    .id_pc_o(pc2), .id_pc4_o(pc42), .id_valid_o(valid2)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .if_misalign_o(misalign2)
`endif
  );

  task automatic expect_from(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // every newly loaded valid IF/ID word must be the next expected PC with its memory word
  always @(posedge clk) begin
    #1;
    if (mon_en && !rst && id_valid && (redirect || !stall || !prev_valid)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got pc %h, nothing expected", id_pc);
      end else begin
        e = exp_q.pop_front();
        if (id_pc !== e || id_pc4 !== e + 32'd4 || id_inst !== mem_word(e)) begin
          n_fail++;
          $display("FAIL scoreboard: got pc %h pc4 %h inst %h, expected pc %h pc4 %h inst %h",
                   id_pc, id_pc4, id_inst, e, e + 32'd4, mem_word(e));
        end
      end
    end
    prev_valid = id_valid;
  end

  task automatic do_reset(input logic [31:0] start);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_from(start);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req !== 1'b0 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: req %b valid %b, expected 0 0", req, id_valid);
    end
    n_checks++;
    if (id_inst !== INST_NOP || id_pc !== 32'h0 || id_pc4 !== 32'h0) begin
      n_fail++; $display("FAIL reset_ifid: inst %h pc %h pc4 %h, expected 00000013 0 0", id_inst, id_pc, id_pc4);
    end
    n_checks++;
    if (addr !== 32'h0 || addr2 !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL reset_pc: addr %h addr2 %h, expected 00000000 fffffffc", addr, addr2);
    end
  endtask

  task automatic test_stream;
    rst = 1'b0;
    expect_from(32'h0);
    mon_en = 1'b1;
    #1;
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h0) begin
      n_fail++; $display("FAIL first_req: req %b addr %h, expected 1 00000000", req, addr);
    end
    @(negedge clk);
    n_checks++;
    if (id_valid !== 1'b0 || req !== 1'b1 || addr !== 32'h4) begin
      n_fail++; $display("FAIL cycle1: valid %b req %b addr %h, expected 0 1 00000004", id_valid, req, addr);
    end
    @(negedge clk);
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      n_fail++; $display("FAIL first_valid: valid %b pc %h, expected 1 00000000", id_valid, id_pc);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * i)) begin
        n_fail++; $display("FAIL throughput: valid %b pc %h, expected 1 %h", id_valid, id_pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_wrap;
    do_reset(32'h0);
    #1;
    n_checks++;
    if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_req: req %b addr %h, expected 1 fffffffc", req2, addr2);
    end
    @(negedge clk);
    n_checks++;
    if (addr2 !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr: addr %h, expected 00000000", addr2);
    end
    @(negedge clk);
    n_checks++;
    if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || pc42 !== 32'h0 || inst2 !== mem_word(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL wrap_first: valid %b pc %h pc4 %h inst %h, expected 1 fffffffc 00000000 %h",
                         valid2, pc2, pc42, inst2, mem_word(32'hFFFF_FFFC));
    end
    @(negedge clk);
    n_checks++;
    if (valid2 !== 1'b1 || pc2 !== 32'h0 || pc42 !== 32'h4) begin
      n_fail++; $display("FAIL wrap_second: valid %b pc %h pc4 %h, expected 1 00000000 00000004", valid2, pc2, pc42);
    end
  endtask

  task automatic test_stall;
    int n_req;
    n_req = 0;
    do_reset(32'h0);
    for (int i = 0; i < 20 && !(id_valid === 1'b1 && id_pc === 32'h8); i++) @(negedge clk);
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h8) begin
      n_fail++; $display("FAIL stall_wait: pc %h valid %b, expected 00000008 1", id_pc, id_valid);
    end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (req === 1'b1) n_req++;
      @(negedge clk);
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h8) begin
        n_fail++; $display("FAIL stall_hold: valid %b pc %h, expected 1 00000008", id_valid, id_pc);
      end
    end
    n_checks++;
    if (n_req > 1) begin
      n_fail++; $display("FAIL stall_issue: %0d requests while stalled, expected at most 1", n_req);
    end
    stall = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0 || exp_q[0] < 32'h20) begin
      n_fail++; $display("FAIL stall_drain: next expected %h, expected at least 00000020", exp_q.size() ? exp_q[0] : 32'h0);
    end
  endtask

  task automatic test_redirect;
    repeat (2) @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    n_checks++;
    if (req !== 1'b0) begin
      n_fail++; $display("FAIL redir_noreq: req %b, expected 0", req);
    end
    @(negedge clk);
    redirect = 1'b0;
    expect_from(32'h100);
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || req !== 1'b1 || addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_t1: valid %b req %b addr %h, expected 0 1 00000100", id_valid, req, addr);
    end
    @(negedge clk);
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_t2: valid %b, expected 0", id_valid);
    end
    @(negedge clk);
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
      n_fail++; $display("FAIL redir_t3: valid %b pc %h, expected 1 00000100", id_valid, id_pc);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_redirect_stall;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h240;
    @(negedge clk);
    redirect = 1'b0;
    expect_from(32'h240);
    n_checks++;
    if (id_valid !== 1'b0 || id_inst !== INST_NOP) begin
      n_fail++; $display("FAIL rs_flush: valid %b inst %h, expected 0 00000013", id_valid, id_inst);
    end
    @(negedge clk);
    stall = 1'b0;
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL rs_t2: valid %b, expected 0", id_valid);
    end
    @(negedge clk);
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h240) begin
      n_fail++; $display("FAIL rs_resume: valid %b pc %h, expected 1 00000240", id_valid, id_pc);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_redirect_drop;
    redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect_pc = 32'h400;
    #1;
    n_checks++;
    if (req !== 1'b0) begin
      n_fail++; $display("FAIL drop_redir_req: req %b, expected 0", req);
    end
    @(negedge clk);
    redirect = 1'b0;
    expect_from(32'h400);
    #1;
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h400 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_restart: req %b addr %h valid %b, expected 1 00000400 0", req, addr, id_valid);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h400) begin
      n_fail++; $display("FAIL drop_target: valid %b pc %h, expected 1 00000400", id_valid, id_pc);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_reset;
    rst = 1'b1; spurious = 1'b1;
    @(negedge clk);
    rst = 1'b0; spurious = 1'b0;
    expect_from(32'h0);
    n_checks++;
    if (id_valid !== 1'b0 || id_inst !== INST_NOP || addr !== 32'h0) begin
      n_fail++; $display("FAIL midrst_state: valid %b inst %h addr %h, expected 0 00000013 00000000", id_valid, id_inst, addr);
    end
    @(negedge clk);
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_stale: valid %b pc %h, expected valid 0", id_valid, id_pc);
    end
    @(negedge clk);
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      n_fail++; $display("FAIL midrst_first: valid %b pc %h, expected 1 00000000", id_valid, id_pc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_misalign;
    redirect = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (misalign !== 1'b1 || req !== 1'b0 || id_valid !== 1'b0) begin
        n_fail++; $display("FAIL misalign_halt: flag %b req %b valid %b, expected 1 0 0", misalign, req, id_valid);
      end
      @(negedge clk);
    end
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    expect_from(32'h200);
    n_checks++;
    if (misalign !== 1'b0) begin
      n_fail++; $display("FAIL misalign_clear: flag %b, expected 0", misalign);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200) begin
      n_fail++; $display("FAIL misalign_resume: valid %b pc %h, expected 1 00000200", id_valid, id_pc);
    end
`else
    expect_from(32'h100);
    #1;
    n_checks++;
    if (addr !== 32'h100 || req !== 1'b1) begin
      n_fail++; $display("FAIL misalign_force: addr %h req %b, expected 00000100 1", addr, req);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
      n_fail++; $display("FAIL misalign_target: valid %b pc %h, expected 1 00000100", id_valid, id_pc);
    end
`endif
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_redirect_drop();
    test_mid_reset();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
